stump_mem_responder: RTL and testbench
======================================

// Module: stump_mem_responder
// PURPOSE
//  Memory-side responder for Stump core data/instruction accesses (mem_ren/mem_wen from the control decoder).
//  Bridges the core's single-request port to a variable-latency SRAM req/ack port.
//  Holds a one-entry posted-write buffer with read forwarding.
//  Gives the core a mem_ready completion pulse.
//  Sits between the Stump datapath and the external memory model.
// PARAMETERS
//  ADDR_W   16  SRAM word-address width; sram_addr = mem_addr[ADDR_W-1:0]
//  TIMEOUT  16  cycles waited for sram_ack before abandoning (used only with STUMP_MEM_TIMEOUT_EN)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst_n       in   1       reset: synchronous, active-low
//  mem_ren     in   1       core read request, held stable until mem_ready
//  mem_wen     in   1       core write request, held stable until mem_ready
//  mem_addr    in   16      core word address
//  mem_wdata   in   16      core write data
//  mem_rdata   out  16      registered read data, valid in mem_ready cycle
//  mem_ready   out  1       one-cycle completion pulse to core
//  sram_req    out  1       SRAM request, held until sram_ack
//  sram_we     out  1       1=write, 0=read; valid while sram_req
//  sram_addr   out  ADDR_W  SRAM address
//  sram_wdata  out  16      SRAM write data
//  sram_ack    in   1       SRAM completion; ignored when sram_req=0
//  sram_rdata  in   16      SRAM read data, valid in sram_ack cycle
//  busy        out  1       FSM not IDLE or write buffer valid
//  err         out  1       sticky timeout flag
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, write buffer invalid. A reset mid-operation discards the buffered write and any pending access.
//  FSM states: IDLE, DRAIN, READ, RESP.
//  - Requests are sampled only in IDLE, so a request still asserted during the RESP cycle is never re-accepted.
//  - Back-to-back: a new request is accepted the cycle after the mem_ready pulse.
//  mem_ren & mem_wen both 1: treated as a write (wen has priority).
//  Write, buffer empty: capture {addr,data} into the buffer; go to RESP; mem_ready=1 next cycle (latency 1).
//  Write, buffer valid: go to DRAIN; when ack arrives, return to IDLE and re-sample.
//  Read, buffer valid, address match: mem_rdata <= buffer data; go to RESP; latency 1; no SRAM access issued.
//  Read, buffer valid, address mismatch: go to DRAIN first, then READ.
//  Read, buffer empty: go to READ.
//  - READ drives sram_req=1, sram_we=0 until sram_ack.
//  - On the ack edge: mem_rdata <= sram_rdata, go to RESP.
//  IDLE, no request, buffer valid: go to DRAIN (background drain).
//  - DRAIN drives sram_req=1, sram_we=1 with buffer addr/data.
//  - On ack: buffer invalid; return to IDLE, or go to READ if a read is pending.
//  RESP: mem_ready=1 for exactly one cycle, then IDLE. mem_rdata holds its value until the next read completes.
//  sram_req/we/addr/wdata are registered and stable from assertion to the ack cycle. sram_req drops the cycle after ack.
// CONFIGURATION
//  STUMP_MEM_TIMEOUT_EN defined:
//  - A counter runs in DRAIN/READ and clears on every state entry.
//  - TIMEOUT cycles without sram_ack: the access is abandoned and sram_req drops.
//  - Read times out: mem_rdata=16'hFFFF, go to RESP.
//  - Drain times out: the buffer is discarded.
//  - err is set on any timeout and held until reset.
//  Undefined: accesses wait indefinitely; err tied 0; TIMEOUT unused.
// STRUCTURE
//  Shared definitions include, next to the Stump opcode/state definitions, holds:
//  - FSM state encodings MR_IDLE/MR_DRAIN/MR_READ/MR_RESP
//  - timeout fill value 16'hFFFF
//  Sub-module stump_mem_wbuf: one-entry write buffer (valid, addr, data, capture/clear, address-match output).
//  FSM, SRAM port registers and timeout counter stay in the top module.
// TESTING
//  1 Reset: rst_n=0 for 2 edges mid-anything -> mem_ready=0, sram_req=0, busy=0, err=0, mem_rdata=0.
//  2 Posted write: wen addr 0x0040 data 0x1234 -> mem_ready next cycle, then sram_req/we=1 addr 0x0040 wdata 0x1234; ack after 3 cycles -> busy=0.
//  3 Forwarding: write 0x0040=0xBEEF, immediate read 0x0040, sram_ack held 0 -> mem_rdata=0xBEEF, ready 1 cycle after accept, no sram read.
//  4 Drain-then-read: write 0x0010=0x5555, read 0x0020, ack latency 2, sram_rdata=0xA5A5:
//    -> SRAM write of 0x0010 completes before SRAM read of 0x0020; mem_rdata=0xA5A5 with ready 1 cycle after read ack.
//  5 Reset mid-READ: rst_n=0 while sram_req=1 -> sram_req=0 next edge; no mem_ready; late ack ignored.
//  6 Timeout (macro on, TIMEOUT=8): read, no ack -> sram_req drops after 8 cycles; mem_rdata=0xFFFF with ready; err=1 held.

Source files
------------

// File: rtl/stump_mem_responder_pkg.sv
// Shared definitions for the Stump memory responder: FSM encodings and fill values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stump_mem_responder_pkg;

  // Core data path width (Stump words are 16 bits)
  localparam int MR_DATA_W = 16;

  typedef logic [MR_DATA_W-1:0] mr_word_t;

  // Responder FSM encodings
  typedef enum logic [1:0] {
    MR_IDLE  = 2'd0,
    MR_DRAIN = 2'd1,
    MR_READ  = 2'd2,
    MR_RESP  = 2'd3
  } mr_state_t;

  // Read data returned to the core when an SRAM read is abandoned
  localparam mr_word_t MR_TMO_FILL = 16'hFFFF;

endpackage

// File: rtl/stump_mem_responder_if.sv
// Core-side request port plus SRAM req/ack port of the Stump memory responder.
// Latency: n/a (wires only).
// Backpressure: core holds its request until mem_ready; responder holds sram_req until sram_ack.
interface stump_mem_responder_if #(
  parameter int ADDR_W = 16
);
  import stump_mem_responder_pkg::*;

  // Core side
  logic              mem_ren;
  logic              mem_wen;
  mr_word_t          mem_addr;
  mr_word_t          mem_wdata;
  mr_word_t          mem_rdata;
  logic              mem_ready;

  // SRAM side
  logic              sram_req;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  mr_word_t          sram_wdata;
  logic              sram_ack;
  mr_word_t          sram_rdata;

  // Responder view
  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_wdata, sram_ack, sram_rdata,
    output mem_rdata, mem_ready, sram_req, sram_we, sram_addr, sram_wdata
  );

  // Core + memory model view
  modport master (
    output mem_ren, mem_wen, mem_addr, mem_wdata, sram_ack, sram_rdata,
    input  mem_rdata, mem_ready, sram_req, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/stump_mem_wbuf.sv
// One-entry posted-write buffer with address-match output for read forwarding.
// Latency: capture/clear take effect on the next clock edge; hit_o is combinational.
// Backpressure: none; the owning FSM only captures when the entry is empty.
module stump_mem_wbuf
  import stump_mem_responder_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     cap_i,
  input  logic     clr_i,
  input  mr_word_t addr_i,
  input  mr_word_t data_i,
  input  mr_word_t cmp_addr_i,
  output logic     vld_o,
  output mr_word_t addr_o,
  output mr_word_t data_o,
  output logic     hit_o
);

  logic     vld_q;
  mr_word_t addr_q;
  mr_word_t data_q;

  // Entry storage: capture wins over clear; the two never coincide in practice
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (cap_i) begin
      vld_q  <= 1'b1;
      addr_q <= addr_i;
      data_q <= data_i;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign hit_o  = vld_q && (addr_q == cmp_addr_i);

endmodule

// File: rtl/stump_mem_responder.sv
// Bridges the Stump core memory port to a req/ack SRAM, with a posted-write buffer and read forwarding.
// Latency: posted write or forwarded read 1 cycle; SRAM read = drain (if any) + SRAM latency + 1.
// Backpressure: core request held until the mem_ready pulse; SRAM request held until sram_ack.
// Optional: STUMP_MEM_TIMEOUT_EN abandons an SRAM access after TIMEOUT request cycles and sets err.
module stump_mem_responder
  import stump_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stump_mem_responder_if.slave   bus,
  output logic                   busy,
  output logic                   err
);

  mr_state_t         state_q, state_d;

  logic              buf_vld, buf_hit, buf_cap, buf_clr;
  mr_word_t          buf_addr, buf_data;
  logic              fwd;

  logic              sram_req_q, sram_we_q;
  logic [ADDR_W-1:0] sram_addr_q;
  mr_word_t          sram_wdata_q;
  mr_word_t          rdata_q;

  logic              wr_req, rd_req, acc_done, tmo;

  // Write has priority when the core raises both strobes
  assign wr_req   = bus.mem_wen;
  assign rd_req   = bus.mem_ren & ~bus.mem_wen;
  // An ack only counts while a request is actually outstanding
  assign acc_done = sram_req_q & bus.sram_ack;

  stump_mem_wbuf u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_i      (buf_cap),
    .clr_i      (buf_clr),
    .addr_i     (bus.mem_addr),
    .data_i     (bus.mem_wdata),
    .cmp_addr_i (bus.mem_addr),
    .vld_o      (buf_vld),
    .addr_o     (buf_addr),
    .data_o     (buf_data),
    .hit_o      (buf_hit)
  );

`ifdef STUMP_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Abandon on the last allowed request cycle if the ack still has not come
  assign tmo = sram_req_q & ~bus.sram_ack & (cnt_q == CNT_W'(TIMEOUT - 1));

  // Request-cycle counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (sram_req_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sticky timeout flag, only reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (tmo) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign tmo            = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the buffer/forwarding strobes that go with each transition
  always_comb begin
    state_d = state_q;
    buf_cap = 1'b0;
    buf_clr = 1'b0;
    fwd     = 1'b0;
    case (state_q)
      MR_IDLE: begin
        if (wr_req) begin
          if (!buf_vld) begin
            buf_cap = 1'b1;
            state_d = MR_RESP;
          end else begin
            state_d = MR_DRAIN;
          end
        end else if (rd_req) begin
          if (buf_hit) begin
            fwd     = 1'b1;
            state_d = MR_RESP;
          end else if (buf_vld) begin
            state_d = MR_DRAIN;
          end else begin
            state_d = MR_READ;
          end
        end else if (buf_vld) begin
          state_d = MR_DRAIN;
        end
      end
      MR_DRAIN: begin
        // A pending read goes straight to SRAM; a pending write re-samples in IDLE
        if (acc_done || tmo) begin
          buf_clr = 1'b1;
          state_d = rd_req ? MR_READ : MR_IDLE;
        end
      end
      MR_READ: begin
        if (acc_done || tmo) begin
          state_d = MR_RESP;
        end
      end
      MR_RESP: begin
        state_d = MR_IDLE;
      end
      default: begin
        state_d = MR_IDLE;
      end
    endcase
  end

  // Core-facing status decoded from the state register
  always_comb begin
    bus.mem_ready = (state_q == MR_RESP);
    busy          = (state_q != MR_IDLE) || buf_vld;
  end

  // SRAM port registers: loaded when an access starts, held until ack, request dropped after.
  // After a drain the request drops for one cycle before the read is issued from READ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else if (acc_done || tmo) begin
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
    end else if (state_q == MR_IDLE && state_d == MR_DRAIN) begin
      sram_req_q   <= 1'b1;
      sram_we_q    <= 1'b1;
      sram_addr_q  <= buf_addr[ADDR_W-1:0];
      sram_wdata_q <= buf_data;
    end else if ((state_q == MR_IDLE && state_d == MR_READ) ||
                 (state_q == MR_READ && !sram_req_q)) begin
      sram_req_q   <= 1'b1;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= bus.mem_addr[ADDR_W-1:0];
    end
  end

  // Read data register: holds until the next read completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (fwd) begin
      rdata_q <= buf_data;
    end else if (state_q == MR_READ && acc_done) begin
      rdata_q <= bus.sram_rdata;
    end else if (state_q == MR_READ && tmo) begin
      rdata_q <= MR_TMO_FILL;
    end
  end

  assign bus.mem_rdata  = rdata_q;
  assign bus.sram_req   = sram_req_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_stump_mem_responder.sv
// Directed bench for stump_mem_responder with a small req/ack SRAM model and access log.
// Latency: checks hand-computed cycle counts for each access type.
// Backpressure: SRAM ack latency programmable; ack can be withheld or forced.
module tb_stump_mem_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic err;

  stump_mem_responder_if #(.ADDR_W(16)) bus();

  stump_mem_responder #(.ADDR_W(16), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // SRAM model state
  int          cyc       = 0;
  int          ack_cyc   = -1;
  int          ack_lat   = 1;
  int          mcnt      = 0;
  bit          ack_en    = 1'b0;
  bit          ack_force = 1'b0;
  logic [15:0] rd_val    = 16'h0000;
  bit          req_seen  = 1'b0;
  int          req_hi    = 0;
  logic [32:0] log_q[$];

  // SRAM model: drives ack after ack_lat request cycles, logs accepted accesses mid-cycle
  initial begin
    bus.sram_ack   = 1'b0;
    bus.sram_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (bus.sram_ack) begin
        bus.sram_ack = 1'b0;
        mcnt = 0;
      end else if (ack_force) begin
        bus.sram_ack = 1'b1;
      end else if (ack_en && bus.sram_req) begin
        mcnt++;
        if (mcnt >= ack_lat) begin
          bus.sram_ack   = 1'b1;
          bus.sram_rdata = rd_val;
        end
      end else begin
        mcnt = 0;
      end
      @(negedge clk);
      if (bus.sram_req) begin
        req_seen = 1'b1;
        req_hi++;
      end
      if (bus.sram_req && bus.sram_ack) begin
        log_q.push_back({bus.sram_we, bus.sram_addr, bus.sram_we ? bus.sram_wdata : 16'h0000});
        ack_cyc = cyc + 1;
      end
    end
  end

  // One core access; lat = cycles sampled before the ready pulse
  task automatic do_access(input bit ren, input bit wen, input logic [15:0] addr,
                           input logic [15:0] wd, output logic [15:0] rd,
                           output int lat, output int rcyc);
    bit got;
    got  = 1'b0;
    lat  = 0;
    rd   = 16'h0000;
    rcyc = -1;
    bus.mem_ren   = ren;
    bus.mem_wen   = wen;
    bus.mem_addr  = addr;
    bus.mem_wdata = wd;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        got  = 1'b1;
        rd   = bus.mem_rdata;
        rcyc = cyc;
      end else begin
        lat++;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL access_wait addr=%h: mem_ready not seen within 200 cycles", addr);
    end
    @(posedge clk); #1;
    bus.mem_ren = 1'b0;
    bus.mem_wen = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL idle_wait: busy still 1 after 100 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.mem_ready); end
    checks++; if (bus.sram_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.sram_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (bus.mem_rdata !== 16'h0000) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", bus.mem_rdata); end
    // Reset while a buffered write is draining: the write must be lost
    @(posedge clk); #1;
    rst_n  = 1'b1;
    ack_en = 1'b0;
    begin
      logic [15:0] rd; int lat; int rc;
      do_access(1'b0, 1'b1, 16'h0077, 16'h7777, rd, lat, rc);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.sram_req) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_mid_drain_req got=0 exp=1"); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    log_q.delete();
    ack_en  = 1'b1;
    ack_lat = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL rst_discard_busy got=%0d busy cycles exp=0", n); end
    checks++; if (log_q.size() !== 0) begin failures++; $display("FAIL rst_discard_log got=%0d accesses exp=0", log_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_posted_write();
    logic [15:0] rd; int lat; int rc; int n; bit seen;
    ack_en  = 1'b1;
    ack_lat = 3;
    log_q.delete();
    req_hi = 0;
    do_access(1'b0, 1'b1, 16'h0040, 16'h1234, rd, lat, rc);
    checks++; if (lat !== 1) begin failures++; $display("FAIL pw_latency got=%0d exp=1", lat); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pw_busy_buffered got=%b exp=1", busy); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.sram_req) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL pw_req_seen got=0 exp=1"); end
    checks++; if (bus.sram_we !== 1'b1) begin failures++; $display("FAIL pw_we got=%b exp=1", bus.sram_we); end
    checks++; if (bus.sram_addr !== 16'h0040) begin failures++; $display("FAIL pw_addr got=%h exp=0040", bus.sram_addr); end
    checks++; if (bus.sram_wdata !== 16'h1234) begin failures++; $display("FAIL pw_wdata got=%h exp=1234", bus.sram_wdata); end
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (!busy) seen = 1'b1;
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL pw_busy_drop got=%0d cycles exp=3", n); end
    checks++; if (bus.sram_req !== 1'b0) begin failures++; $display("FAIL pw_req_drop got=%b exp=0", bus.sram_req); end
    checks++; if (req_hi !== 3) begin failures++; $display("FAIL pw_req_cycles got=%0d exp=3", req_hi); end
    checks++; if (log_q.size() !== 1) begin failures++; $display("FAIL pw_log_size got=%0d exp=1", log_q.size()); end
    checks++; if (log_q[0] !== {1'b1, 16'h0040, 16'h1234}) begin failures++; $display("FAIL pw_log0 got=%h exp=%h", log_q[0], {1'b1, 16'h0040, 16'h1234}); end
    @(posedge clk); #1;
  endtask

  task automatic test_forwarding();
    logic [15:0] rd; int lat; int rc;
    ack_en = 1'b0;
    log_q.delete();
    do_access(1'b0, 1'b1, 16'h0040, 16'hBEEF, rd, lat, rc);
    req_seen = 1'b0;
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, rd, lat, rc);
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL fwd_rdata got=%h exp=beef", rd); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL fwd_latency got=%0d exp=1", lat); end
    checks++; if (req_seen !== 1'b0) begin failures++; $display("FAIL fwd_no_sram got=%b exp=0", req_seen); end
    ack_en  = 1'b1;
    ack_lat = 1;
    wait_idle();
    checks++; if (log_q.size() !== 1) begin failures++; $display("FAIL fwd_log_size got=%0d exp=1", log_q.size()); end
    checks++; if (log_q[0] !== {1'b1, 16'h0040, 16'hBEEF}) begin failures++; $display("FAIL fwd_log0 got=%h exp=%h", log_q[0], {1'b1, 16'h0040, 16'hBEEF}); end
  endtask

  task automatic test_drain_read();
    logic [15:0] rd; int lat; int rc;
    ack_en  = 1'b1;
    ack_lat = 2;
    rd_val  = 16'hA5A5;
    log_q.delete();
    do_access(1'b0, 1'b1, 16'h0010, 16'h5555, rd, lat, rc);
    do_access(1'b1, 1'b0, 16'h0020, 16'h0000, rd, lat, rc);
    checks++; if (rd !== 16'hA5A5) begin failures++; $display("FAIL dr_rdata got=%h exp=a5a5", rd); end
    checks++; if (lat !== 6) begin failures++; $display("FAIL dr_latency got=%0d exp=6", lat); end
    checks++; if (rc !== ack_cyc) begin failures++; $display("FAIL dr_ready_after_ack got=cycle %0d exp=cycle %0d", rc, ack_cyc); end
    checks++; if (log_q.size() !== 2) begin failures++; $display("FAIL dr_log_size got=%0d exp=2", log_q.size()); end
    checks++; if (log_q[0] !== {1'b1, 16'h0010, 16'h5555}) begin failures++; $display("FAIL dr_log0 got=%h exp=%h", log_q[0], {1'b1, 16'h0010, 16'h5555}); end
    checks++; if (log_q[1] !== {1'b0, 16'h0020, 16'h0000}) begin failures++; $display("FAIL dr_log1 got=%h exp=%h", log_q[1], {1'b0, 16'h0020, 16'h0000}); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; int lat; int rc;
    ack_en  = 1'b1;
    ack_lat = 1;
    log_q.delete();
    do_access(1'b0, 1'b1, 16'h0100, 16'h1111, rd, lat, rc);
    checks++; if (lat !== 1) begin failures++; $display("FAIL b2b_wr0_latency got=%0d exp=1", lat); end
    do_access(1'b0, 1'b1, 16'h0101, 16'h2222, rd, lat, rc);
    checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_wr1_latency got=%0d exp=3", lat); end
    do_access(1'b1, 1'b0, 16'h0101, 16'h0000, rd, lat, rc);
    checks++; if (rd !== 16'h2222) begin failures++; $display("FAIL b2b_fwd_rdata got=%h exp=2222", rd); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL b2b_fwd_latency got=%0d exp=1", lat); end
    // Both strobes set: treated as a write
    do_access(1'b1, 1'b1, 16'h0102, 16'h3333, rd, lat, rc);
    checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_rw_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 16'h2222) begin failures++; $display("FAIL b2b_rdata_hold got=%h exp=2222", rd); end
    wait_idle();
    checks++; if (log_q.size() !== 3) begin failures++; $display("FAIL b2b_log_size got=%0d exp=3", log_q.size()); end
    checks++; if (log_q[0] !== {1'b1, 16'h0100, 16'h1111}) begin failures++; $display("FAIL b2b_log0 got=%h exp=%h", log_q[0], {1'b1, 16'h0100, 16'h1111}); end
    checks++; if (log_q[1] !== {1'b1, 16'h0101, 16'h2222}) begin failures++; $display("FAIL b2b_log1 got=%h exp=%h", log_q[1], {1'b1, 16'h0101, 16'h2222}); end
    checks++; if (log_q[2] !== {1'b1, 16'h0102, 16'h3333}) begin failures++; $display("FAIL b2b_log2 got=%h exp=%h", log_q[2], {1'b1, 16'h0102, 16'h3333}); end
  endtask

  task automatic test_reset_mid_read();
    bit seen; int nrdy; int nreq;
    ack_en = 1'b0;
    bus.mem_ren  = 1'b1;
    bus.mem_addr = 16'h0030;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.sram_req) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rmr_req_seen got=0 exp=1"); end
    checks++; if (bus.sram_we !== 1'b0) begin failures++; $display("FAIL rmr_we got=%b exp=0", bus.sram_we); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.mem_ren = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.sram_req !== 1'b0) begin failures++; $display("FAIL rmr_req_cleared got=%b exp=0", bus.sram_req); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    nrdy = 0;
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_ready) nrdy++;
      if (bus.sram_req) nreq++;
    end
    checks++; if (nrdy !== 0) begin failures++; $display("FAIL rmr_no_ready got=%0d pulses exp=0", nrdy); end
    checks++; if (nreq !== 0) begin failures++; $display("FAIL rmr_no_req got=%0d cycles exp=0", nreq); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmr_busy got=%b exp=0", busy); end
    checks++; if (bus.mem_rdata !== 16'h0000) begin failures++; $display("FAIL rmr_rdata got=%h exp=0000", bus.mem_rdata); end
    @(posedge clk); #1;
  endtask

`ifdef STUMP_MEM_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] rd; int lat; int rc;
    ack_en = 1'b0;
    req_hi = 0;
    do_access(1'b1, 1'b0, 16'h0050, 16'h0000, rd, lat, rc);
    checks++; if (rd !== 16'hFFFF) begin failures++; $display("FAIL tmo_rdata got=%h exp=ffff", rd); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL tmo_latency got=%0d exp=9", lat); end
    checks++; if (req_hi !== 8) begin failures++; $display("FAIL tmo_req_cycles got=%0d exp=8", req_hi); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err_held got=%b exp=1", err); end
    checks++; if (bus.sram_req !== 1'b0) begin failures++; $display("FAIL tmo_req_low got=%b exp=0", bus.sram_req); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_reset got=%b exp=0", err); end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_err_tied();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_tied got=%b exp=0", err); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
    test_reset();
    test_posted_write();
    test_forwarding();
    test_drain_read();
    test_back_to_back();
    test_reset_mid_read();
`ifdef STUMP_MEM_TIMEOUT_EN
    test_timeout();
`else
    test_err_tied();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
